// File: rtl/and_slot_pkg.sv
// Shared definitions for the 74x08 gate-slot arbiter.
// Holds the default slot count, the per-requester need width and the FSM state type.
// No logic; imported by the arbiter top and its round-robin picker.
package and_slot_pkg;

    localparam int SLOTS_DEF = 4;
    localparam int NEED_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-one finder: lowest set bit of vec at or after ptr, wrapping.
// Latency: purely combinational, result valid in the same cycle as vec/ptr.
// Backpressure: none; found=0 when vec is empty.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;

    // Rotate so bit 0 of rot is the requester at ptr.
    assign dbl = {vec, vec};
    assign rot = N'(dbl >> ptr);

    // First set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (W+1)'(k);
                if (sum >= (W+1)'(N)) begin
                    sum = sum - (W+1)'(N);
                end
                idx = sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/and_slot_arbiter.sv
// Hands out gates of one 74x08 package to requesters, round-robin, no head-of-line blocking.
// Latency: req seen in IDLE at cycle N -> one-cycle gnt/gnt_mask pulse at N+2.
// Backpressure: requesters hold req until granted; unfit requests wait while others are served.
module and_slot_arbiter
    import and_slot_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SLOTS   = SLOTS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*NEED_W-1:0] req_need,
    input  logic [NUM_REQ-1:0]        rel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SLOTS-1:0]          gnt_mask,
    output logic [SLOTS-1:0]          busy_mask,
    output logic                      pkg_full,
    output logic                      err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [SLOTS-1:0]     gnt_mask_r;
    logic [IDX_W-1:0]     owner_idx [SLOTS];
    logic [SLOTS-1:0]     owner_vld;

    logic [NEED_W-1:0]    need [NUM_REQ];
    logic [NUM_REQ-1:0]   need_ok;
    logic [NUM_REQ-1:0]   owns;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   fit;
    logic [NUM_REQ-1:0]   rel_ok;
    logic [SLOTS-1:0]     rel_clr;
    logic [SLOTS-1:0]     alloc_mask;
    logic                 bad_req;
    logic                 bad_rel;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    int                   free_cnt;
    int                   taken;

    assign busy_mask = owner_vld;
    assign pkg_full  = &owner_vld;
    // Reset kills a grant already on the wire in the same cycle.
    assign gnt       = rst ? '0 : gnt_r;
    assign gnt_mask  = rst ? '0 : gnt_mask_r;

    // Unpack needs and work out which requesters already own a slot.
    always_comb begin
        owns    = '0;
        need_ok = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            need[i]    = req_need[i*NEED_W +: NEED_W];
            need_ok[i] = (need[i] != '0) && (int'(need[i]) <= SLOTS);
            for (int s = 0; s < SLOTS; s++) begin
                if (owner_vld[s] && (owner_idx[s] == IDX_W'(i))) begin
                    owns[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = req & ~owns & need_ok;
    assign rel_ok   = rel & owns;
    assign bad_rel  = |(rel & ~owns);
    assign bad_req  = (state == ST_IDLE) && (|(req & ~owns & ~need_ok));

    // Free count uses this cycle's table only, so a concurrent release cannot inflate it.
    always_comb begin
        free_cnt = 0;
        fit      = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (!owner_vld[s]) begin
                free_cnt = free_cnt + 1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            fit[i] = eligible[i] && (int'(need[i]) <= free_cnt);
        end
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .vec   (fit),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner gets its need count of the lowest-indexed free slots; releasers lose all theirs.
    always_comb begin
        alloc_mask = '0;
        rel_clr    = '0;
        taken      = 0;
        for (int s = 0; s < SLOTS; s++) begin
            if (!owner_vld[s] && (taken < int'(need[pick_idx]))) begin
                alloc_mask[s] = 1'b1;
                taken         = taken + 1;
            end
            rel_clr[s] = owner_vld[s] && rel_ok[owner_idx[s]];
        end
    end

    // Arbitration FSM plus owner table; releases apply in every state, grants land at end of GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            win_idx    <= '0;
            gnt_r      <= '0;
            gnt_mask_r <= '0;
            err        <= 1'b0;
            owner_vld  <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                owner_idx[s] <= '0;
            end
        end else begin
            err        <= bad_req | bad_rel;
            gnt_r      <= '0;
            gnt_mask_r <= '0;
            owner_vld  <= owner_vld & ~rel_clr;
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (pick_found) begin
                        state      <= ST_GRANT;
                        win_idx    <= pick_idx;
                        gnt_r      <= NUM_REQ'(1) << pick_idx;
                        gnt_mask_r <= alloc_mask;
                        rr_ptr     <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Granted slots were free, so they never collide with rel_clr.
                    owner_vld <= (owner_vld & ~rel_clr) | gnt_mask_r;
                    for (int s = 0; s < SLOTS; s++) begin
                        if (gnt_mask_r[s]) begin
                            owner_idx[s] <= win_idx;
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_slot_arbiter.sv
// Randomised and directed bench for and_slot_arbiter against a slot-level reference model.
// Latency: model tracks the IDLE/ARB/GRANT timeline and predicts every output every cycle.
// Backpressure: requesters hold req; releases are pulsed by the bench.
module tb_and_slot_arbiter;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*3-1:0] req_need;
    logic [N-1:0]   rel;
    logic [N-1:0]   gnt;
    logic [S-1:0]   gnt_mask;
    logic [S-1:0]   busy_mask;
    logic           pkg_full;
    logic           err;

    always #5 clk = ~clk;

    and_slot_arbiter #(
        .NUM_REQ (N),
        .SLOTS   (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_need  (req_need),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_mask  (gnt_mask),
        .busy_mask (busy_mask),
        .pkg_full  (pkg_full),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 arbitrate, 2 grant; owner[s] = -1 when free.
    int           m_phase;
    int           m_ptr;
    int           m_owner [S];
    int           m_win;
    logic [S-1:0] m_mask;
    logic         m_err;

    logic [N-1:0] o_gnt;
    logic [S-1:0] o_mask;
    logic [S-1:0] o_busy;
    logic         o_full;
    logic         o_err;

    function automatic logic [11:0] nd(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic int need_of(input int i);
        return int'(req_need[i*3 +: 3]);
    endfunction

    function automatic bit m_owns(input int i);
        for (int s = 0; s < S; s++) if (m_owner[s] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [S-1:0] m_busy();
        logic [S-1:0] b = '0;
        for (int s = 0; s < S; s++) b[s] = (m_owner[s] != -1);
        return b;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_win   = 0;
        m_mask  = '0;
        m_err   = 1'b0;
        for (int s = 0; s < S; s++) m_owner[s] = -1;
    endtask

    task automatic model_step();
        int  nxt [S];
        int  free;
        int  cnt;
        int  w;
        int  i;
        bit  e;
        bit  found;
        logic [S-1:0] mask;
        if (rst) begin
            model_reset();
            return;
        end
        e    = 1'b0;
        free = 0;
        for (int s = 0; s < S; s++) begin
            nxt[s] = m_owner[s];
            if (m_owner[s] == -1) free++;
        end
        for (int r = 0; r < N; r++) begin
            if (rel[r]) begin
                if (m_owns(r)) begin
                    for (int s = 0; s < S; s++) if (m_owner[s] == r) nxt[s] = -1;
                end else begin
                    e = 1'b1;
                end
            end
            if (m_phase == 0 && req[r] && !m_owns(r) && (need_of(r) < 1 || need_of(r) > S)) e = 1'b1;
        end
        case (m_phase)
            0: begin
                for (int r = 0; r < N; r++)
                    if (req[r] && !m_owns(r) && need_of(r) >= 1 && need_of(r) <= S) m_phase = 1;
            end
            1: begin
                found = 1'b0;
                w     = 0;
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (!found && req[i] && !m_owns(i) && need_of(i) >= 1 && need_of(i) <= free) begin
                        found = 1'b1;
                        w     = i;
                    end
                end
                if (found) begin
                    mask = '0;
                    cnt  = 0;
                    for (int s = 0; s < S; s++) begin
                        if (m_owner[s] == -1 && cnt < need_of(w)) begin
                            mask[s] = 1'b1;
                            cnt++;
                        end
                    end
                    m_win   = w;
                    m_mask  = mask;
                    m_ptr   = (w + 1) % N;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                for (int s = 0; s < S; s++) if (m_mask[s]) nxt[s] = m_win;
                m_phase = 0;
            end
        endcase
        for (int s = 0; s < S; s++) m_owner[s] = nxt[s];
        m_err = e;
    endtask

    // One clock cycle: drive, compare every output with the model at negedge, advance the model.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [11:0] ndv, input logic [N-1:0] rl);
        logic [N-1:0] eg;
        logic [S-1:0] em;
        rst      = r;
        req      = rq;
        req_need = ndv;
        rel      = rl;
        @(negedge clk);
        o_gnt  = gnt;
        o_mask = gnt_mask;
        o_busy = busy_mask;
        o_full = pkg_full;
        o_err  = err;
        eg = (m_phase == 2 && !r) ? N'(1) << m_win : '0;
        em = (m_phase == 2 && !r) ? m_mask : '0;
        check("gnt", o_gnt, eg);
        check("gnt_mask", o_mask, em);
        check("busy_mask", o_busy, m_busy());
        check("pkg_full", o_full, &m_busy());
        check("err", o_err, m_err);
        model_step();
        @(posedge clk);
        #1;
    endtask

    int           order [$];
    logic [N-1:0] rl_next;
    logic [N-1:0] rq_r;
    logic [N-1:0] rl_r;
    logic [11:0]  nd_r;
    int           nv;
    int           exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req = '0; req_need = '0; rel = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state, then single request of two gates.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_busy", o_busy, 0);
        check("rst_gnt", o_gnt, 0);
        check("rst_err", o_err, 0);
        check("rst_full", o_full, 0);
        cyc(0, 4'b0001, nd(2, 0, 0, 0), 0);
        check("lat_n", o_gnt, 0);
        cyc(0, 4'b0001, nd(2, 0, 0, 0), 0);
        check("lat_n1", o_gnt, 0);
        cyc(0, 0, 0, 0);
        check("lat_n2_gnt", o_gnt, 4'b0001);
        check("lat_n2_mask", o_mask, 4'b0011);
        cyc(0, 0, 0, 0);
        check("lat_busy", o_busy, 4'b0011);

        // Skip an unfit requester: 3 owns 0011, req0 needs 3, req1 needs 2.
        cyc(1, 0, 0, 0);
        cyc(0, 4'b1000, nd(0, 0, 0, 2), 0);
        cyc(0, 4'b1000, nd(0, 0, 0, 2), 0);
        cyc(0, 4'b0011, nd(3, 2, 0, 0), 0);
        check("skip_g3", o_gnt, 4'b1000);
        check("skip_m3", o_mask, 4'b0011);
        cyc(0, 4'b0011, nd(3, 2, 0, 0), 0);
        cyc(0, 4'b0011, nd(3, 2, 0, 0), 0);
        cyc(0, 0, 0, 0);
        check("skip_gnt", o_gnt, 4'b0010);
        check("skip_mask", o_mask, 4'b1100);
        cyc(0, 0, 0, 0);
        check("skip_busy", o_busy, 4'b1111);
        check("skip_full", o_full, 1);

        // Owner of 0011 releases while 1100 stays held.
        cyc(0, 0, 0, 4'b1000);
        cyc(0, 0, 0, 0);
        check("rel_busy", o_busy, 4'b1100);
        check("rel_err", o_err, 0);

        // Release from a non-owner is flagged and ignored.
        cyc(0, 0, 0, 4'b0100);
        cyc(0, 0, 0, 0);
        check("bad_rel_err", o_err, 1);
        check("bad_rel_busy", o_busy, 4'b1100);
        cyc(0, 0, 0, 4'b0010);
        check("bad_rel_pulse", o_err, 0);
        cyc(0, 0, 0, 0);
        check("rel1_busy", o_busy, 0);

        // Round-robin fairness at need 1 with immediate release.
        cyc(1, 0, 0, 0);
        rl_next = '0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            cyc(0, 4'b1111, nd(1, 1, 1, 1), rl_next);
            rl_next = o_gnt;
            for (int i = 0; i < N; i++) if (o_gnt[i]) order.push_back(i);
        end
        check("rr_count", order.size(), 5);
        for (int k = 0; k < 5 && k < order.size(); k++) check("rr_order", order[k], exp_order[k]);
        cyc(0, 0, 0, rl_next);

        // Reset during the grant cycle drops the grant.
        cyc(1, 0, 0, 0);
        cyc(0, 4'b0001, nd(2, 0, 0, 0), 0);
        cyc(0, 4'b0001, nd(2, 0, 0, 0), 0);
        cyc(1, 4'b0001, nd(2, 0, 0, 0), 0);
        check("rstg_gnt", o_gnt, 0);
        check("rstg_mask", o_mask, 0);
        cyc(0, 0, 0, 0);
        check("rstg_busy", o_busy, 0);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            rq_r = N'($urandom);
            nd_r = '0;
            rl_r = '0;
            for (int i = 0; i < N; i++) begin
                nv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, S));
                nd_r[i*3 +: 3] = 3'(nv);
                if (m_owns(i) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0)) rl_r[i] = 1'b1;
            end
            cyc(($urandom_range(0, 99) == 0), rq_r, nd_r, rl_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
